// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator/demodulator pair: default counter
// width and the demodulator state encoding.
package pwm_pkg;

  localparam int unsigned PWM_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_demod_if.sv
// PWM line plus decoded results; master drives the line, slave is the demodulator.
interface pwm_demod_if
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
);

  logic             pwm_in;
  logic [WIDTH-1:0] value;
  logic             valid;
  logic             locked;
  logic             error;

  modport master (output pwm_in, input value, valid, locked, error);
  modport slave  (input pwm_in, output value, valid, locked, error);

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer for the PWM line with registered rise/fall strobes;
// level is delayed so it lines up with the strobes.
module sync_edge (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic sync_dly_q, sync_dly_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d     = din;
    sync_d     = meta_q;
    sync_dly_d = sync_q;
    rise_d     = sync_q & ~sync_dly_q;
    fall_d     = ~sync_q & sync_dly_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      sync_dly_q <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      meta_q     <= meta_d;
      sync_q     <= sync_d;
      sync_dly_q <= sync_dly_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign level = sync_dly_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/pwm_demod.sv
// PWM demodulator: recovers the generator duty value from the low time of each
// 2^WIDTH-cycle period, tracks lock and flags malformed or stuck-low periods.
module pwm_demod
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH
) (
  input  logic       clock,
  input  logic       reset_n,
  pwm_demod_if.slave bus
);

  // state   | meaning
  // ST_IDLE | no reference rise yet (after reset or a stuck-low line)
  // ST_HIGH | line high since the last reference rise
  // ST_LOW  | line low, waiting for the rise that closes the period

  localparam logic [WIDTH:0] CNT_ONE = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0] CNT_P   = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] CNT_PM1 = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] CNT_PP1 = CNT_P | CNT_ONE;

  logic             s, rise, fall;
  logic             hi_timeout, stuck_low;
  pwm_state_e       state_q, state_d;
  logic [WIDTH:0]   per_cnt_q, per_cnt_d;
  logic [WIDTH:0]   low_cnt_q, low_cnt_d;
  logic [WIDTH:0]   hi_cnt_q, hi_cnt_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             error_q, error_d;

  sync_edge u_sync_edge (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (bus.pwm_in),
    .level   (s),
    .rise    (rise),
    .fall    (fall)
  );

  // A rise always wins over the constant-high timeout, so the two never collide.
  assign hi_timeout = s & ~rise & (hi_cnt_q == CNT_P);
  assign stuck_low  = ~s & (low_cnt_q == CNT_PM1) & (state_q != ST_HIGH);

  always_comb begin
    per_cnt_d = per_cnt_q;
    low_cnt_d = low_cnt_q;
    hi_cnt_d  = hi_cnt_q;

    if (rise) begin
      per_cnt_d = CNT_ONE;
    end else if (per_cnt_q != CNT_PP1) begin
      per_cnt_d = per_cnt_q + CNT_ONE;
    end

    if (rise) begin
      low_cnt_d = '0;
    end else if (!s && (low_cnt_q != CNT_P)) begin
      low_cnt_d = low_cnt_q + CNT_ONE;
    end

    if (rise || hi_timeout) begin
      hi_cnt_d = CNT_ONE;
    end else if (!s) begin
      hi_cnt_d = '0;
    end else begin
      hi_cnt_d = hi_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    error_d  = 1'b0;
    locked_d = locked_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
        end else if (hi_timeout) begin
          state_d  = ST_HIGH;
          value_d  = '0;
          valid_d  = 1'b1;
          locked_d = 1'b1;
        end else if (stuck_low) begin
          error_d  = 1'b1;
          locked_d = 1'b0;
        end
      end
      ST_HIGH: begin
        if (fall) begin
          state_d = ST_LOW;
        end else if (hi_timeout) begin
          value_d  = '0;
          valid_d  = 1'b1;
          locked_d = 1'b1;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_d = ST_HIGH;
          if (per_cnt_q == CNT_P) begin
            value_d  = low_cnt_q[WIDTH-1:0];
            valid_d  = 1'b1;
            locked_d = 1'b1;
          end else begin
            error_d  = 1'b1;
            locked_d = 1'b0;
          end
        end else if (stuck_low) begin
          state_d  = ST_IDLE;
          error_d  = 1'b1;
          locked_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      per_cnt_q <= '0;
      low_cnt_q <= '0;
      hi_cnt_q  <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      low_cnt_q <= low_cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      error_q   <= error_d;
    end
  end

  assign bus.value  = value_q;
  assign bus.valid  = valid_q;
  assign bus.locked = locked_q;
  assign bus.error  = error_q;

endmodule

// File: tb/tb_pwm_demod.sv
// Directed bench for pwm_demod: drives PWM waveforms cycle by cycle and checks
// decoded values, pulse timing, lock, error and reset behaviour.
module tb_pwm_demod;
  import pwm_pkg::*;

  localparam int unsigned W = PWM_WIDTH;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc     = 0;

  int n_checks   = 0;
  int n_errors   = 0;
  int n_both     = 0;
  int n_spurious = 0;
  logic [W-1:0] prev_value = '0;

  int valid_cyc[$];
  int valid_val[$];
  int error_cyc[$];
  int rise_cyc[$];
  int fall_cyc[$];

  int exp_s2 [6] = '{5, 15, 15, 15, 3, 3};
  int exp_s3 [3] = '{3, 4, 4};
  int exp_s4 [5] = '{4, 0, 0, 0, 0};

  pwm_demod_if #(.WIDTH(W)) bus ();

  pwm_demod #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int idx);
    if (idx < q.size()) return q[idx];
    return -1;
  endfunction

  task automatic clear_stats();
    valid_cyc.delete();
    valid_val.delete();
    error_cyc.delete();
    rise_cyc.delete();
    fall_cyc.delete();
  endtask

  // Sample outputs on the falling edge, then drive the next line level.
  task automatic step(input logic b);
    @(negedge clock);
    if (bus.valid) begin
      valid_cyc.push_back(cyc);
      valid_val.push_back(int'(bus.value));
    end
    if (bus.error) error_cyc.push_back(cyc);
    if (bus.valid && bus.error) n_both++;
    if (reset_n && !bus.valid && (bus.value != prev_value)) n_spurious++;
    prev_value = bus.value;
    if (b && !bus.pwm_in) rise_cyc.push_back(cyc);
    if (!b && bus.pwm_in) fall_cyc.push_back(cyc);
    bus.pwm_in = b;
  endtask

  task automatic gen(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1);
    for (int i = 0; i < lo; i++) step(1'b0);
  endtask

  initial begin
    bus.pwm_in = 1'b0;
    reset_n    = 1'b0;

    // reset state
    repeat (3) step(1'b0);
    check_eq("rst_value",  32'(bus.value),  0);
    check_eq("rst_valid",  32'(bus.valid),  0);
    check_eq("rst_locked", 32'(bus.locked), 0);
    check_eq("rst_error",  32'(bus.error),  0);
    check_eq("rst_state",  32'(dut.state_q), 32'(ST_IDLE));
    #2 reset_n = 1'b1;
    repeat (3) step(1'b0);
    check_eq("rel_no_valid", valid_cyc.size(), 0);
    check_eq("rel_no_error", error_cyc.size(), 0);

    // value 5 stream: lock after second rise, valid every 16 clocks
    clear_stats();
    repeat (6) gen(11, 5);
    check_eq("s1_nvalid", valid_cyc.size(), 5);
    check_eq("s1_nerror", error_cyc.size(), 0);
    check_eq("s1_locked", 32'(bus.locked), 1);
    check_eq("s1_latency", qget(valid_cyc, 0), qget(rise_cyc, 1) + 4);
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("s1_val%0d", i), qget(valid_val, i), 5);
    for (int i = 1; i < 5; i++)
      check_eq($sformatf("s1_int%0d", i), qget(valid_cyc, i) - qget(valid_cyc, i - 1), 16);

    // value 15 (1-cycle high pulse), then step to 3
    clear_stats();
    repeat (3) gen(1, 15);
    repeat (3) gen(13, 3);
    check_eq("s2_nvalid", valid_cyc.size(), 6);
    check_eq("s2_nerror", error_cyc.size(), 0);
    for (int i = 0; i < 6; i++)
      check_eq($sformatf("s2_val%0d", i), qget(valid_val, i), exp_s2[i]);

    // 12-cycle periods after lock, then back to 16-cycle periods
    clear_stats();
    repeat (3) gen(8, 4);
    gen(12, 4);
    check_eq("s3_unlocked", 32'(bus.locked), 0);
    check_eq("s3_value_hold", 32'(bus.value), 3);
    check_eq("s3_err_latency", qget(error_cyc, 0), qget(rise_cyc, 1) + 4);
    repeat (2) gen(12, 4);
    check_eq("s3_nerror", error_cyc.size(), 3);
    check_eq("s3_nvalid", valid_cyc.size(), 3);
    check_eq("s3_relocked", 32'(bus.locked), 1);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("s3_val%0d", i), qget(valid_val, i), exp_s3[i]);

    // constant high: valid with value 0 every 16 clocks
    clear_stats();
    repeat (69) step(1'b1);
    check_eq("s4_nvalid", valid_cyc.size(), 5);
    check_eq("s4_nerror", error_cyc.size(), 0);
    check_eq("s4_locked", 32'(bus.locked), 1);
    check_eq("s4_first_lat", qget(valid_cyc, 1), qget(rise_cyc, 0) + 20);
    for (int i = 0; i < 5; i++)
      check_eq($sformatf("s4_val%0d", i), qget(valid_val, i), exp_s4[i]);
    for (int i = 2; i < 5; i++)
      check_eq($sformatf("s4_int%0d", i), qget(valid_cyc, i) - qget(valid_cyc, i - 1), 16);

    // stuck low after lock
    clear_stats();
    repeat (20) step(1'b0);
    check_eq("s5_nerror", error_cyc.size(), 1);
    check_eq("s5_err_time", qget(error_cyc, 0), qget(fall_cyc, 0) + 19);
    check_eq("s5_nvalid", valid_cyc.size(), 0);
    check_eq("s5_unlocked", 32'(bus.locked), 0);
    check_eq("s5_value_hold", 32'(bus.value), 0);
    check_eq("s5_state_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // value 9 stream, reset mid-LOW, relock after one full period
    clear_stats();
    repeat (2) gen(7, 9);
    repeat (7) step(1'b1);
    repeat (7) step(1'b0);
    check_eq("s6_pre_nvalid", valid_cyc.size(), 2);
    check_eq("s6_pre_value", 32'(bus.value), 9);
    check_eq("s6_pre_locked", 32'(bus.locked), 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("s6_rst_value",  32'(bus.value),  0);
    check_eq("s6_rst_valid",  32'(bus.valid),  0);
    check_eq("s6_rst_locked", 32'(bus.locked), 0);
    check_eq("s6_rst_error",  32'(bus.error),  0);
    repeat (3) step(1'b0);
    #2 reset_n = 1'b1;
    repeat (2) step(1'b0);
    clear_stats();
    repeat (2) gen(7, 9);
    repeat (5) step(1'b1);
    check_eq("s6_nvalid", valid_cyc.size(), 2);
    check_eq("s6_nerror", error_cyc.size(), 0);
    check_eq("s6_first_valid", qget(valid_cyc, 0), qget(rise_cyc, 1) + 4);
    check_eq("s6_val0", qget(valid_val, 0), 9);
    check_eq("s6_val1", qget(valid_val, 1), 9);
    check_eq("s6_locked", 32'(bus.locked), 1);

    // properties watched over the whole run
    check_eq("valid_error_overlap", n_both, 0);
    check_eq("value_change_without_valid", n_spurious, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
